// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator bridging the core's valid/ready memory port.
// Define AXI_MASTER_MISALIGN_CHECK_EN to reject word-misaligned requests locally.
module axi_lite_master #(
    parameter logic [2:0] AXI_PROT = 3'b000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] axi_araddr,
    output logic        axi_arvalid,
    input  logic        axi_arready,
    output logic [2:0]  axi_arprot,
    input  logic [31:0] axi_rdata,
    input  logic [1:0]  axi_rresp,
    input  logic        axi_rvalid,
    output logic        axi_rready,
    output logic [31:0] axi_awaddr,
    output logic        axi_awvalid,
    input  logic        axi_awready,
    output logic [2:0]  axi_awprot,
    output logic [31:0] axi_wdata,
    output logic [3:0]  axi_wstrb,
    output logic        axi_wvalid,
    input  logic        axi_wready,
    input  logic [1:0]  axi_bresp,
    input  logic        axi_bvalid,
    output logic        axi_bready
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR   = 3'd1,
        R    = 3'd2,
        AW_W = 3'd3,
        B    = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic req_fire;
    logic misalign;
    logic aw_ok;
    logic w_ok;
    logic unused_resp;

    assign req_fire = req_valid && (state_q == IDLE);

`ifdef AXI_MASTER_MISALIGN_CHECK_EN
    assign misalign = (req_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // A finished channel stays satisfied; a live one completes on its ready.
    assign aw_ok = aw_done_q || axi_awready;
    assign w_ok  = w_done_q || axi_wready;

    assign unused_resp = ^{axi_rresp[0], axi_bresp[0]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_fire && !misalign) begin
                    state_d = req_we ? AW_W : AR;
                end
            end
            AR: begin
                if (axi_arready) state_d = R;
            end
            R: begin
                if (axi_rvalid) state_d = IDLE;
            end
            AW_W: begin
                if (aw_ok && w_ok) state_d = B;
            end
            B: begin
                if (axi_bvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready   = (state_q == IDLE);
        axi_arvalid = (state_q == AR);
        axi_rready  = (state_q == R);
        axi_awvalid = (state_q == AW_W) && !aw_done_q;
        axi_wvalid  = (state_q == AW_W) && !w_done_q;
        axi_bready  = (state_q == B);
    end

    always_comb begin
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        unique case (state_q)
            IDLE: begin
                if (req_fire) begin
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    wstrb_d   = req_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (misalign) begin
                        resp_valid_d = 1'b1;
                        resp_rdata_d = 32'h0;
                        resp_err_d   = 1'b1;
                    end
                end
            end
            R: begin
                if (axi_rvalid) begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = axi_rdata;
                    resp_err_d   = axi_rresp[1];
                end
            end
            AW_W: begin
                if (axi_awready) aw_done_d = 1'b1;
                if (axi_wready) w_done_d = 1'b1;
            end
            B: begin
                if (axi_bvalid) begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = 32'h0;
                    resp_err_d   = axi_bresp[1];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            wstrb_q      <= 4'h0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign axi_araddr = addr_q;
    assign axi_awaddr = addr_q;
    assign axi_wdata  = wdata_q;
    assign axi_wstrb  = wstrb_q;
    assign axi_arprot = AXI_PROT;
    assign axi_awprot = AXI_PROT;

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master with a hand-scripted AXI slave.
// Honours AXI_MASTER_MISALIGN_CHECK_EN for the misalignment case.
module tb_axi_lite_master;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] axi_araddr;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [2:0]  axi_arprot;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid;
    logic        axi_rready;
    logic [31:0] axi_awaddr;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [2:0]  axi_awprot;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;

    int checks;
    int errors;

    axi_lite_master dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_wstrb   (req_wstrb),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .axi_araddr  (axi_araddr),
        .axi_arvalid (axi_arvalid),
        .axi_arready (axi_arready),
        .axi_arprot  (axi_arprot),
        .axi_rdata   (axi_rdata),
        .axi_rresp   (axi_rresp),
        .axi_rvalid  (axi_rvalid),
        .axi_rready  (axi_rready),
        .axi_awaddr  (axi_awaddr),
        .axi_awvalid (axi_awvalid),
        .axi_awready (axi_awready),
        .axi_awprot  (axi_awprot),
        .axi_wdata   (axi_wdata),
        .axi_wstrb   (axi_wstrb),
        .axi_wvalid  (axi_wvalid),
        .axi_wready  (axi_wready),
        .axi_bresp   (axi_bresp),
        .axi_bvalid  (axi_bvalid),
        .axi_bready  (axi_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_addr    = 32'h0;
        req_wdata   = 32'h0;
        req_wstrb   = 4'h0;
        axi_arready = 1'b0;
        axi_rdata   = 32'h0;
        axi_rresp   = 2'b00;
        axi_rvalid  = 1'b0;
        axi_awready = 1'b0;
        axi_wready  = 1'b0;
        axi_bresp   = 2'b00;
        axi_bvalid  = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();
        rstn = 1'b0;
        repeat (2) step();

        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_arvalid", 32'(axi_arvalid), 32'd0);
        chk("rst_awvalid", 32'(axi_awvalid), 32'd0);
        chk("rst_wvalid", 32'(axi_wvalid), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_araddr", axi_araddr, 32'h0);
        chk("rst_wstrb", 32'(axi_wstrb), 32'h0);
        rstn = 1'b1;
        step();

        // zero-wait read
        req_valid   = 1'b1;
        req_we      = 1'b0;
        req_addr    = 32'h0000_bff8;
        axi_arready = 1'b1;
        step();
        req_valid = 1'b0;
        chk("rd_arvalid_c1", 32'(axi_arvalid), 32'd1);
        chk("rd_araddr", axi_araddr, 32'h0000_bff8);
        chk("rd_arprot", 32'(axi_arprot), 32'd0);
        chk("rd_req_ready_c1", 32'(req_ready), 32'd0);
        step();
        chk("rd_arvalid_c2", 32'(axi_arvalid), 32'd0);
        chk("rd_rready_c2", 32'(axi_rready), 32'd1);
        axi_rvalid = 1'b1;
        axi_rdata  = 32'h1234_5678;
        axi_rresp  = 2'b00;
        step();
        axi_rvalid = 1'b0;
        chk("rd_resp_valid_c3", 32'(resp_valid), 32'd1);
        chk("rd_rdata", resp_rdata, 32'h1234_5678);
        chk("rd_err", 32'(resp_err), 32'd0);
        chk("rd_rready_c3", 32'(axi_rready), 32'd0);
        step();
        chk("rd_resp_pulse", 32'(resp_valid), 32'd0);
        chk("rd_rdata_hold", resp_rdata, 32'h1234_5678);

        // write with AW delayed, W immediate
        idle_inputs();
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = 32'h0000_4000;
        req_wdata  = 32'hdead_beef;
        req_wstrb  = 4'b0011;
        axi_wready = 1'b1;
        step();
        req_valid = 1'b0;
        chk("wr_awvalid_c1", 32'(axi_awvalid), 32'd1);
        chk("wr_wvalid_c1", 32'(axi_wvalid), 32'd1);
        chk("wr_awaddr", axi_awaddr, 32'h0000_4000);
        chk("wr_wdata", axi_wdata, 32'hdead_beef);
        chk("wr_wstrb", 32'(axi_wstrb), 32'h3);
        step();
        chk("wr_wvalid_c2", 32'(axi_wvalid), 32'd0);
        chk("wr_awvalid_c2", 32'(axi_awvalid), 32'd1);
        step();
        chk("wr_awvalid_c3", 32'(axi_awvalid), 32'd1);
        chk("wr_bready_c3", 32'(axi_bready), 32'd0);
        step();
        axi_awready = 1'b1;
        chk("wr_awvalid_c4", 32'(axi_awvalid), 32'd1);
        chk("wr_wvalid_c4", 32'(axi_wvalid), 32'd0);
        step();
        axi_awready = 1'b0;
        chk("wr_awvalid_c5", 32'(axi_awvalid), 32'd0);
        chk("wr_bready_c5", 32'(axi_bready), 32'd1);
        chk("wr_resp_c5", 32'(resp_valid), 32'd0);
        axi_bvalid = 1'b1;
        axi_bresp  = 2'b00;
        step();
        axi_bvalid = 1'b0;
        chk("wr_resp_valid", 32'(resp_valid), 32'd1);
        chk("wr_err", 32'(resp_err), 32'd0);
        chk("wr_rdata_zero", resp_rdata, 32'h0);
        step();
        chk("wr_resp_pulse", 32'(resp_valid), 32'd0);

        // read with SLVERR
        idle_inputs();
        req_valid   = 1'b1;
        req_addr    = 32'h0000_8000;
        axi_arready = 1'b1;
        step();
        req_valid = 1'b0;
        chk("er_araddr", axi_araddr, 32'h0000_8000);
        step();
        axi_rvalid = 1'b1;
        axi_rdata  = 32'hcafe_0001;
        axi_rresp  = 2'b10;
        step();
        axi_rvalid = 1'b0;
        axi_rresp  = 2'b00;
        chk("er_resp_valid", 32'(resp_valid), 32'd1);
        chk("er_err", 32'(resp_err), 32'd1);
        step();
        chk("er_resp_pulse", 32'(resp_valid), 32'd0);
        chk("er_err_hold", 32'(resp_err), 32'd1);

        // back-to-back read then write with req_valid held
        idle_inputs();
        axi_arready = 1'b1;
        axi_awready = 1'b1;
        axi_wready  = 1'b1;
        req_valid   = 1'b1;
        req_we      = 1'b0;
        req_addr    = 32'h0000_0100;
        step();
        req_we    = 1'b1;
        req_addr  = 32'h0000_0200;
        req_wdata = 32'h1122_3344;
        req_wstrb = 4'hf;
        chk("bb_arvalid_c1", 32'(axi_arvalid), 32'd1);
        chk("bb_awvalid_c1", 32'(axi_awvalid), 32'd0);
        step();
        axi_rvalid = 1'b1;
        axi_rdata  = 32'h0000_a5a5;
        step();
        axi_rvalid = 1'b0;
        chk("bb_resp1_valid", 32'(resp_valid), 32'd1);
        chk("bb_resp1_rdata", resp_rdata, 32'h0000_a5a5);
        chk("bb_req_ready_c3", 32'(req_ready), 32'd1);
        chk("bb_no_valid_c3", 32'({axi_arvalid, axi_awvalid, axi_wvalid}), 32'd0);
        step();
        req_valid = 1'b0;
        chk("bb_awvalid_c4", 32'(axi_awvalid), 32'd1);
        chk("bb_wvalid_c4", 32'(axi_wvalid), 32'd1);
        chk("bb_arvalid_c4", 32'(axi_arvalid), 32'd0);
        chk("bb_awaddr", axi_awaddr, 32'h0000_0200);
        chk("bb_resp_c4", 32'(resp_valid), 32'd0);
        step();
        chk("bb_valids_c5", 32'({axi_awvalid, axi_wvalid}), 32'd0);
        chk("bb_bready_c5", 32'(axi_bready), 32'd1);
        axi_bvalid = 1'b1;
        step();
        axi_bvalid = 1'b0;
        chk("bb_resp2_valid", 32'(resp_valid), 32'd1);
        chk("bb_resp2_rdata", resp_rdata, 32'h0);
        step();

        // reset while waiting in R
        idle_inputs();
        req_valid   = 1'b1;
        req_addr    = 32'h0000_0300;
        axi_arready = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        chk("rs_rready_pre", 32'(axi_rready), 32'd1);
        rstn = 1'b0;
        #1;
        chk("rs_rready", 32'(axi_rready), 32'd0);
        chk("rs_arvalid", 32'(axi_arvalid), 32'd0);
        chk("rs_resp_valid", 32'(resp_valid), 32'd0);
        chk("rs_araddr", axi_araddr, 32'h0);
        step();
        rstn = 1'b1;
        step();
        chk("rs_req_ready", 32'(req_ready), 32'd1);
        chk("rs_rready_post", 32'(axi_rready), 32'd0);

        // misaligned read
        idle_inputs();
        req_valid   = 1'b1;
        req_addr    = 32'h0000_4002;
        axi_arready = 1'b1;
        step();
        req_valid = 1'b0;
`ifdef AXI_MASTER_MISALIGN_CHECK_EN
        chk("ma_arvalid", 32'(axi_arvalid), 32'd0);
        chk("ma_resp_valid", 32'(resp_valid), 32'd1);
        chk("ma_err", 32'(resp_err), 32'd1);
        chk("ma_rdata", resp_rdata, 32'h0);
        chk("ma_req_ready", 32'(req_ready), 32'd1);
        step();
        chk("ma_resp_pulse", 32'(resp_valid), 32'd0);
`else
        chk("ma_arvalid", 32'(axi_arvalid), 32'd1);
        chk("ma_araddr", axi_araddr, 32'h0000_4002);
        chk("ma_resp_c1", 32'(resp_valid), 32'd0);
        step();
        axi_rvalid = 1'b1;
        axi_rdata  = 32'h0bad_f00d;
        step();
        axi_rvalid = 1'b0;
        chk("ma_resp_valid", 32'(resp_valid), 32'd1);
        chk("ma_err", 32'(resp_err), 32'd0);
        chk("ma_rdata", resp_rdata, 32'h0bad_f00d);
`endif
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
